// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder_pkg
// Description : Shared definitions for the UART command decoder: parser
//               states, command opcodes, default frame marker and the frame
//               checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_decoder_pkg;

  // Parser states. Byte order inside a frame is SYNC, CMD, DHI, DLO, CSUM.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CSUM = 3'd4,
    ST_EXEC = 3'd5
  } state_t;

  // Command opcodes carried in CMD[7:6]; 2'b11 is reserved.
  localparam logic [1:0] OP_WR     = 2'b00;
  localparam logic [1:0] OP_ARM    = 2'b01;
  localparam logic [1:0] OP_DISARM = 2'b10;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame checksum: XOR of the three payload bytes.
  function automatic logic [7:0] calc_csum(input logic [7:0] cmd,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return cmd ^ dhi ^ dlo;
  endfunction

endpackage : uart_cmd_decoder_pkg
`default_nettype wire

// File: rtl/uart_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_idle_timer
// Description : Inter-byte idle timer. Counts clock cycles while 'run' is
//               high, restarts from zero on 'clear', and flags 'expired' in
//               the cycle where the count has reached TIMEOUT_CYC-1.
// Ports       : clk     - system clock
//               rst     - asynchronous active-low reset
//               clear   - restart the count (a byte was received)
//               run     - count enable (parser is inside a frame)
//               expired - idle limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || !run) begin
      // Held at zero outside a frame so every frame starts a fresh window.
      r_cnt <= '0;
    end else if (r_cnt != c_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A byte arriving in the same cycle wins over the timeout.
  assign expired = run && !clear && (r_cnt == c_last);

endmodule : uart_idle_timer
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Parses 5-byte command frames (SYNC, CMD, DHI, DLO, CSUM)
//               from a UART receiver and turns them into register writes or
//               capture arm/disarm actions. Bad frames bump a saturating
//               error counter.
// Ports       : clk       - system clock, rising edge
//               rst       - asynchronous active-low reset
//               rx_stb    - one-cycle strobe, rx_dat/rx_err valid
//               rx_dat    - received byte
//               rx_err    - framing error on the strobed byte
//               fifo_full - capture FIFO full, forces armed low
//               reg_we    - one-cycle register write strobe
//               reg_addr  - register address (holds between writes)
//               reg_wdat  - register write data (holds between writes)
//               armed     - capture enable level
//               err_cnt   - saturating rejected-frame count
//               busy      - parser is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_stb,
  input  logic [7:0]  rx_dat,
  input  logic        rx_err,
  input  logic        fifo_full,
  output logic        reg_we,
  output logic [5:0]  reg_addr,
  output logic [15:0] reg_wdat,
  output logic        armed,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cmd;
  logic [7:0]  r_dhi;
  logic [7:0]  r_dlo;
  logic        r_reg_we;
  logic [5:0]  r_reg_addr;
  logic [15:0] r_reg_wdat;
  logic        r_armed;
  logic [7:0]  r_err_cnt;

  logic        w_run;
  logic        w_expired;
  logic        w_csum_ok;
  logic [1:0]  w_op;
  logic        w_err;
  logic        w_latch_cmd;
  logic        w_latch_dhi;
  logic        w_latch_dlo;
  logic        w_issue_wr;
  logic        w_do_arm;
  logic        w_do_disarm;

  assign w_run     = (r_state != ST_IDLE);
  assign w_op      = r_cmd[7:6];
  assign w_csum_ok = (calc_csum(r_cmd, r_dhi, r_dlo) == rx_dat);

  uart_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_stb),
    .run     (w_run),
    .expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // Parser state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-cycle actions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_latch_cmd = 1'b0;
    w_latch_dhi = 1'b0;
    w_latch_dlo = 1'b0;
    w_issue_wr  = 1'b0;
    w_do_arm    = 1'b0;
    w_do_disarm = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Errored bytes are dropped here; only a clean marker opens a frame.
        if (rx_stb && !rx_err && (rx_dat == SYNC_BYTE)) begin
          w_state_nxt = ST_CMD;
        end
      end

      ST_CMD, ST_DHI, ST_DLO: begin
        if (rx_stb) begin
          if (rx_err) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            // Any byte value, including SYNC_BYTE, is payload here.
            w_latch_cmd = (r_state == ST_CMD);
            w_latch_dhi = (r_state == ST_DHI);
            w_latch_dlo = (r_state == ST_DLO);
            unique case (r_state)
              ST_CMD:  w_state_nxt = ST_DHI;
              ST_DHI:  w_state_nxt = ST_DLO;
              default: w_state_nxt = ST_CSUM;
            endcase
          end
        end else if (w_expired) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_CSUM: begin
        if (rx_stb) begin
          if (!rx_err && w_csum_ok) begin
            w_state_nxt = ST_EXEC;
            // Write outputs are registered on this edge so reg_we is high
            // for exactly the EXEC cycle.
            w_issue_wr  = (w_op == OP_WR);
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_expired) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_EXEC: begin
        w_state_nxt = ST_IDLE;
        w_do_arm    = (w_op == OP_ARM);
        w_do_disarm = (w_op == OP_DISARM);
        // Reserved opcode and a framing error during EXEC share one count.
        w_err       = (w_op == 2'b11) || (rx_stb && rx_err) || w_expired;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Payload capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd <= '0;
      r_dhi <= '0;
      r_dlo <= '0;
    end else begin
      if (w_latch_cmd) r_cmd <= rx_dat;
      if (w_latch_dhi) r_dhi <= rx_dat;
      if (w_latch_dlo) r_dlo <= rx_dat;
    end
  end

  // --------------------------------------------------------------------------
  // Register write port; address and data hold between writes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_we   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_wdat <= '0;
    end else begin
      r_reg_we <= w_issue_wr;
      if (w_issue_wr) begin
        r_reg_addr <= r_cmd[5:0];
        r_reg_wdat <= {r_dhi, r_dlo};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture enable; a full FIFO overrides an arm command on the same edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= 1'b0;
    end else if (fifo_full) begin
      r_armed <= 1'b0;
    end else if (w_do_arm) begin
      r_armed <= 1'b1;
    end else if (w_do_disarm) begin
      r_armed <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating rejected-frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign reg_we   = r_reg_we;
  assign reg_addr = r_reg_addr;
  assign reg_wdat = r_reg_wdat;
  assign armed    = r_armed;
  assign err_cnt  = r_err_cnt;
  assign busy     = (r_state != ST_IDLE);

endmodule : uart_cmd_decoder
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Directed self-checking bench for uart_cmd_decoder. Inputs
//               change on the falling clock edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_stb;
  logic [7:0]  rx_dat;
  logic        rx_err;
  logic        fifo_full;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wdat;
  logic        armed;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_cmd_decoder #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (48000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_stb    (rx_stb),
    .rx_dat    (rx_dat),
    .rx_err    (rx_err),
    .fifo_full (fifo_full),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdat  (reg_wdat),
    .armed     (armed),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; strobes one byte across the next rising edge
  // and returns at the following falling edge.
  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_stb = 1'b1;
    rx_dat = b;
    rx_err = e;
    @(negedge clk);
    rx_stb = 1'b0;
    rx_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] s);
    send_byte(8'hA5, 1'b0);
    send_byte(c, 1'b0);
    send_byte(h, 1'b0);
    send_byte(l, 1'b0);
    send_byte(s, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    rx_stb    = 1'b0;
    rx_dat    = 8'h00;
    rx_err    = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdat", reg_wdat, 0);
    chk("rst_armed", armed, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Non-marker byte and errored marker are ignored in IDLE
    send_byte(8'h12, 1'b0);
    chk("idle_junk_busy", busy, 0);
    send_byte(8'hA5, 1'b1);
    chk("idle_errsync_busy", busy, 0);
    chk("idle_errsync_err", err_cnt, 0);

    // Good write frame: A5 05 12 34 23
    send_frame(8'h05, 8'h12, 8'h34, 8'h23);
    chk("wr_reg_we", reg_we, 1);
    chk("wr_reg_addr", reg_addr, 6'h05);
    chk("wr_reg_wdat", reg_wdat, 16'h1234);
    chk("wr_busy_exec", busy, 1);
    chk("wr_err_cnt", err_cnt, 0);
    @(negedge clk);
    chk("wr_we_one_cycle", reg_we, 0);
    chk("wr_addr_hold", reg_addr, 6'h05);
    chk("wr_wdat_hold", reg_wdat, 16'h1234);
    chk("wr_busy_after", busy, 0);

    // Bad checksum: A5 05 12 34 00
    send_frame(8'h05, 8'h12, 8'h34, 8'h00);
    chk("badcs_reg_we", reg_we, 0);
    chk("badcs_err_cnt", err_cnt, 1);
    chk("badcs_busy", busy, 0);

    // Marker value as data: A5 3F A5 5A C0
    send_frame(8'h3F, 8'hA5, 8'h5A, 8'hC0);
    chk("midsync_reg_we", reg_we, 1);
    chk("midsync_addr", reg_addr, 6'h3F);
    chk("midsync_wdat", reg_wdat, 16'hA55A);
    @(negedge clk);

    // Arm frame
    send_frame(8'h40, 8'h00, 8'h00, 8'h40);
    chk("arm_no_we", reg_we, 0);
    @(negedge clk);
    chk("arm_armed", armed, 1);
    chk("arm_addr_hold", reg_addr, 6'h3F);

    // fifo_full clears armed
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    chk("full_disarms", armed, 0);

    // Re-arm, then disarm command
    send_frame(8'h40, 8'h00, 8'h00, 8'h40);
    @(negedge clk);
    chk("rearm_armed", armed, 1);
    send_frame(8'h80, 8'h00, 8'h00, 8'h80);
    chk("disarm_no_we", reg_we, 0);
    @(negedge clk);
    chk("disarm_armed", armed, 0);

    // Arm EXEC coincident with fifo_full
    send_frame(8'h40, 8'h00, 8'h00, 8'h40);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    chk("arm_vs_full", armed, 0);

    // Reserved opcode: error path in EXEC
    send_frame(8'hC0, 8'h00, 8'h00, 8'hC0);
    chk("rsvd_no_we", reg_we, 0);
    @(negedge clk);
    chk("rsvd_err_cnt", err_cnt, 2);
    chk("rsvd_busy", busy, 0);
    chk("rsvd_armed", armed, 0);

    // rx_err on DHI drops the frame; the tail bytes are discarded in IDLE
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b1);
    chk("dhi_err_busy", busy, 0);
    chk("dhi_err_cnt", err_cnt, 3);
    send_byte(8'h34, 1'b0);
    send_byte(8'h23, 1'b0);
    chk("dhi_tail_we", reg_we, 0);
    chk("dhi_tail_busy", busy, 0);

    // Idle timeout inside a frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    repeat (47999) @(negedge clk);
    chk("tmo_before_busy", busy, 1);
    chk("tmo_before_err", err_cnt, 3);
    @(negedge clk);
    chk("tmo_busy", busy, 0);
    chk("tmo_err_cnt", err_cnt, 4);
    send_frame(8'h05, 8'h12, 8'h34, 8'h23);
    chk("tmo_then_we", reg_we, 1);
    chk("tmo_then_addr", reg_addr, 6'h05);
    chk("tmo_then_wdat", reg_wdat, 16'h1234);
    @(negedge clk);

    // Reset mid-frame after DLO, then the CSUM byte
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_err", err_cnt, 0);
    chk("async_rst_addr", reg_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'h23, 1'b0);
    chk("rstmid_no_we", reg_we, 0);
    chk("rstmid_err", err_cnt, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    chk("rstmid_no_we_late", reg_we, 0);

    // Error counter saturation
    for (int i = 0; i < 254; i++) begin
      send_frame(8'h05, 8'h12, 8'h34, 8'h00);
    end
    chk("sat_fe", err_cnt, 8'hFE);
    send_frame(8'h05, 8'h12, 8'h34, 8'h00);
    chk("sat_ff", err_cnt, 8'hFF);
    send_frame(8'h05, 8'h12, 8'h34, 8'h00);
    send_frame(8'h05, 8'h12, 8'h34, 8'h00);
    chk("sat_hold", err_cnt, 8'hFF);
    chk("sat_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_cmd_decoder
`default_nettype wire
